// File: rtl/dram_bridge_pkg.sv
// Shared types and constants for the round-robin DRAM bridge.
package dram_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B,
        ST_RESP
    } bridgeState_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Width of the per-state handshake wait counter.
    localparam int unsigned TO_W = 10;

endpackage

// File: rtl/dram_rr_bridge_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N_CH-1:0]  grant,
    output logic [IDX_W-1:0] idx
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk candidates ptr, ptr+1, ... modulo N_CH and take the first request.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int unsigned off = 0; off < N_CH; off++) begin
            sum = {1'b0, ptr} + SUM_W'(off);
            if (sum >= SUM_W'(N_CH)) begin
                sum = sum - SUM_W'(N_CH);
            end
            cand = sum[IDX_W-1:0];
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/dram_rr_bridge.sv
// N-channel round-robin bridge onto a single AXI-lite DRAM port, one
// transaction in flight, with per-handshake timeout and error reporting.
module dram_rr_bridge
    import dram_bridge_pkg::*;
#(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          req_valid,
    input  logic [N_CH-1:0]          req_write,
    input  logic [N_CH*ADDR_W-1:0]   req_addr,
    input  logic [N_CH*DATA_W-1:0]   req_wdata,
    output logic [N_CH-1:0]          req_ready,
    output logic [N_CH-1:0]          resp_valid,
    output logic [DATA_W-1:0]        resp_data,
    output logic                     resp_err,
    output logic                     ar_valid,
    output logic [ADDR_W-1:0]        ar_addr,
    input  logic                     ar_ready,
    input  logic                     r_valid,
    input  logic [DATA_W-1:0]        r_data,
    input  logic [1:0]               r_resp,
    output logic                     r_ready,
    output logic                     aw_valid,
    output logic [ADDR_W-1:0]        aw_addr,
    input  logic                     aw_ready,
    output logic                     w_valid,
    output logic [DATA_W-1:0]        w_data,
    input  logic                     w_ready,
    input  logic                     b_valid,
    input  logic [1:0]               b_resp,
    output logic                     b_ready
);

    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    bridgeState_t      state, stateNext;
    logic [IDX_W-1:0]  ptr, grantIdx;
    logic [N_CH-1:0]   grant, curCh;
    logic [ADDR_W-1:0] curAddr, selAddr;
    logic [DATA_W-1:0] curWdata, selWdata, respDataNext;
    logic              selWrite, arbEn, timeUp;
    logic [1:0]        respCodeNext;
    logic [TO_W-1:0]   waitCnt;

    assign arbEn     = (state == ST_IDLE) && rst_n;
    assign req_ready = grant;
    assign ar_addr   = curAddr;
    assign aw_addr   = curAddr;
    assign w_data    = curWdata;

    // Abort once TIMEOUT cycles have been spent waiting in the current state.
    assign timeUp = (waitCnt == TO_W'(TIMEOUT - 1));

    rr_arbiter #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .en    (arbEn),
        .grant (grant),
        .idx   (grantIdx)
    );

    // Mux the winning channel's request fields.
    always_comb begin
        selWrite = 1'b0;
        selAddr  = '0;
        selWdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                selWrite = req_write[i];
                selAddr  = req_addr[i*ADDR_W +: ADDR_W];
                selWdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic and the response that RESP will present.
    always_comb begin
        stateNext    = state;
        respCodeNext = RESP_OKAY;
        respDataNext = '0;
        unique case (state)
            ST_IDLE: begin
                if (|grant) begin
                    stateNext = selWrite ? ST_AW : ST_AR;
                end
            end
            ST_AR: begin
                if (ar_ready) begin
                    stateNext = ST_R;
                end else if (timeUp) begin
                    stateNext    = ST_RESP;
                    respCodeNext = RESP_SLVERR;
                end
            end
            ST_R: begin
                if (r_valid) begin
                    stateNext    = ST_RESP;
                    respCodeNext = r_resp;
                    respDataNext = (r_resp == RESP_OKAY) ? r_data : '0;
                end else if (timeUp) begin
                    stateNext    = ST_RESP;
                    respCodeNext = RESP_SLVERR;
                end
            end
            ST_AW: begin
                if (aw_ready) begin
                    stateNext = ST_W;
                end else if (timeUp) begin
                    stateNext    = ST_RESP;
                    respCodeNext = RESP_SLVERR;
                end
            end
            ST_W: begin
                if (w_ready) begin
                    stateNext = ST_B;
                end else if (timeUp) begin
                    stateNext    = ST_RESP;
                    respCodeNext = RESP_SLVERR;
                end
            end
            ST_B: begin
                if (b_valid) begin
                    stateNext    = ST_RESP;
                    respCodeNext = b_resp;
                end else if (timeUp) begin
                    stateNext    = ST_RESP;
                    respCodeNext = RESP_SLVERR;
                end
            end
            ST_RESP: begin
                stateNext = ST_IDLE;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // Grant latch, rr pointer, wait counter and registered AXI/response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            curCh      <= '0;
            curAddr    <= '0;
            curWdata   <= '0;
            waitCnt    <= '0;
            ar_valid   <= 1'b0;
            r_ready    <= 1'b0;
            aw_valid   <= 1'b0;
            w_valid    <= 1'b0;
            b_ready    <= 1'b0;
            resp_valid <= '0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
        end else begin
            if (state == ST_IDLE && |grant) begin
                curCh    <= grant;
                curAddr  <= selAddr;
                curWdata <= selWdata;
                ptr      <= (grantIdx == IDX_W'(N_CH - 1)) ? '0 : grantIdx + IDX_W'(1);
            end
            if (stateNext != state) begin
                waitCnt <= '0;
            end else if (state inside {ST_AR, ST_R, ST_AW, ST_W, ST_B}) begin
                waitCnt <= waitCnt + TO_W'(1);
            end
            ar_valid   <= (stateNext == ST_AR);
            r_ready    <= (stateNext == ST_R);
            aw_valid   <= (stateNext == ST_AW);
            w_valid    <= (stateNext == ST_W);
            b_ready    <= (stateNext == ST_B);
            resp_valid <= (stateNext == ST_RESP) ? curCh : '0;
            resp_err   <= (stateNext == ST_RESP) && (respCodeNext != RESP_OKAY);
            resp_data  <= (stateNext == ST_RESP) ? respDataNext : '0;
        end
    end

endmodule

// File: tb/tb_dram_rr_bridge.sv
// Scoreboard bench for dram_rr_bridge with a configurable AXI-lite slave.
module tb_dram_rr_bridge;

    localparam int NCH = 4;
    localparam int AW  = 17;
    localparam int DW  = 64;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NCH-1:0]    req_valid = '0, req_write = '0;
    logic [NCH*AW-1:0] req_addr = '0;
    logic [NCH*DW-1:0] req_wdata = '0;
    logic [NCH-1:0]    req_ready, resp_valid;
    logic [DW-1:0]     resp_data;
    logic              resp_err;
    logic              ar_valid, r_ready, aw_valid, w_valid, b_ready;
    logic              ar_ready = 1'b0, r_valid = 1'b0, aw_ready = 1'b0, w_ready = 1'b0, b_valid = 1'b0;
    logic [AW-1:0]     ar_addr, aw_addr;
    logic [DW-1:0]     w_data, r_data = '0;
    logic [1:0]        r_resp = 2'b00, b_resp = 2'b00;

    typedef struct {
        logic [NCH-1:0] ch;
        logic           err;
        logic [DW-1:0]  data;
    } exp_t;

    exp_t expQ[$];
    int   grantLog[$];
    int   total = 0, bad = 0, cyc = 0;
    int   grantCyc[NCH], respCycCh[NCH];
    int   rRdyRiseCyc = 0, reqReadyCnt = 0, respCnt = 0;

    // slave behaviour knobs
    int            arDly = 0, rDly = 0, awDly = 0, wDly = 0, bDly = 0;
    logic          rNever = 1'b0, rXor = 1'b0, awDone = 1'b0;
    logic [1:0]    rRespCode = 2'b00, bRespCode = 2'b00;
    logic [DW-1:0] rBase = '0, capW = '0;
    logic [AW-1:0] capAr = '0, capAw = '0;

    dram_rr_bridge #(
        .N_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_ready(ar_ready),
        .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp), .r_ready(r_ready),
        .aw_valid(aw_valid), .aw_addr(aw_addr), .aw_ready(aw_ready),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Slave model and protocol monitor, evaluated on each falling edge.
    initial begin : slave_mon
        int   arC, rC, awC, wC, bC;
        logic pArV, pArR, pAwV, pAwR, pWV, pWR, pRRdy;
        logic [AW-1:0] pArA, pAwA;
        logic [DW-1:0] pWD;
        exp_t e;
        arC = 0; rC = 0; awC = 0; wC = 0; bC = 0;
        pArV = 0; pArR = 0; pAwV = 0; pAwR = 0; pWV = 0; pWR = 0; pRRdy = 0;
        pArA = '0; pAwA = '0; pWD = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pArV && pArR) capAr = pArA;
            if (pAwV && pAwR) begin capAw = pAwA; awDone = 1'b1; end
            if (pWV && pWR) capW = pWD;
            if (rst_n && pArV && !pArR) begin
                total++;
                if (ar_valid !== 1'b1 || ar_addr !== pArA) begin
                    bad++;
                    $display("FAIL ar_stable: ar_valid=%b ar_addr=%h, required 1/%h", ar_valid, ar_addr, pArA);
                end
            end
            if (rst_n && pAwV && !pAwR) begin
                total++;
                if (aw_valid !== 1'b1 || aw_addr !== pAwA) begin
                    bad++;
                    $display("FAIL aw_stable: aw_valid=%b aw_addr=%h, required 1/%h", aw_valid, aw_addr, pAwA);
                end
            end
            if (rst_n && pWV && !pWR) begin
                total++;
                if (w_valid !== 1'b1 || w_data !== pWD) begin
                    bad++;
                    $display("FAIL w_stable: w_valid=%b w_data=%h, required 1/%h", w_valid, w_data, pWD);
                end
            end
            if (w_valid === 1'b1) begin
                total++;
                if (aw_valid !== 1'b0 || !awDone) begin
                    bad++;
                    $display("FAIL w_order: w_valid with aw_valid=%b aw_done=%b, required 0/1", aw_valid, awDone);
                end
            end
            if (r_ready && !pRRdy) rRdyRiseCyc = cyc;
            if (|req_ready) begin
                total++;
                if (!$onehot(req_ready)) begin
                    bad++;
                    $display("FAIL req_ready_onehot: req_ready=%b, required one-hot", req_ready);
                end
                for (int i = 0; i < NCH; i++) begin
                    if (req_ready[i]) begin
                        grantCyc[i] = cyc;
                        grantLog.push_back(i);
                    end
                end
                reqReadyCnt++;
                awDone = 1'b0;
            end
            if (|resp_valid) begin
                total++;
                respCnt++;
                for (int i = 0; i < NCH; i++) if (resp_valid[i]) respCycCh[i] = cyc;
                if (expQ.size() == 0) begin
                    bad++;
                    $display("FAIL resp_unexpected: resp_valid=%b err=%b data=%h, required no response",
                             resp_valid, resp_err, resp_data);
                end else begin
                    e = expQ.pop_front();
                    if (resp_valid !== e.ch || resp_err !== e.err || resp_data !== e.data) begin
                        bad++;
                        $display("FAIL resp: valid=%b err=%b data=%h, required %b/%b/%h",
                                 resp_valid, resp_err, resp_data, e.ch, e.err, e.data);
                    end
                end
            end
            // drive slave handshakes for the coming rising edge
            if (ar_valid) begin ar_ready = (arC >= arDly); arC++; end
            else begin ar_ready = 1'b0; arC = 0; end
            if (r_ready && !rNever) begin r_valid = (rC >= rDly); rC++; end
            else begin r_valid = 1'b0; rC = 0; end
            r_data = rXor ? (rBase ^ 64'(capAr)) : rBase;
            r_resp = rRespCode;
            if (aw_valid) begin aw_ready = (awC >= awDly); awC++; end
            else begin aw_ready = 1'b0; awC = 0; end
            if (w_valid) begin w_ready = (wC >= wDly); wC++; end
            else begin w_ready = 1'b0; wC = 0; end
            if (b_ready) begin b_valid = (bC >= bDly); bC++; end
            else begin b_valid = 1'b0; bC = 0; end
            b_resp = bRespCode;
            pArV = ar_valid; pArR = ar_ready; pArA = ar_addr;
            pAwV = aw_valid; pAwR = aw_ready; pAwA = aw_addr;
            pWV = w_valid; pWR = w_ready; pWD = w_data;
            pRRdy = r_ready;
        end
    end

    task automatic push_exp(input int ch, input logic err, input logic [DW-1:0] data);
        exp_t e;
        e.ch = NCH'(1) << ch;
        e.err = err;
        e.data = data;
        expQ.push_back(e);
    endtask

    task automatic raise(input int ch, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[ch] = 1'b1;
        req_write[ch] = wr;
        req_addr[ch*AW +: AW] = a;
        req_wdata[ch*DW +: DW] = d;
    endtask

    task automatic await_grant(input int ch);
        int budget = 200;
        logic seen = 1'b0;
        while (!seen && budget > 0) begin
            @(negedge clk); #1;
            if (req_ready[ch]) seen = 1'b1;
            budget--;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL grant_timeout: ch%0d req_ready=0, required a grant", ch);
        end
        @(posedge clk); #2;
        req_valid[ch] = 1'b0;
    endtask

    task automatic issue(input int ch, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #2;
        raise(ch, wr, a, d);
        await_grant(ch);
    endtask

    task automatic wait_drain(input string name);
        int b = 100;
        while (expQ.size() != 0 && b > 0) begin @(negedge clk); #1; b--; end
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d responses outstanding, required 0", name, expQ.size());
            expQ.delete();
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic check_outputs_zero(input string name);
        total++;
        if ({req_ready, resp_valid, resp_err, resp_data, ar_valid, ar_addr, r_ready,
             aw_valid, aw_addr, w_valid, w_data, b_ready} !== '0) begin
            bad++;
            $display("FAIL %s: outputs req_ready=%b resp_valid=%b ar=%b r_rdy=%b aw=%b w=%b b_rdy=%b, required all 0",
                     name, req_ready, resp_valid, ar_valid, r_ready, aw_valid, w_valid, b_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_outputs_zero("idle_after_reset");
    endtask

    task automatic test_round_robin();
        int base, startCnt, respStart, budget, got;
        logic [AW-1:0] a;
        rXor = 1'b1; rBase = 64'hA5A5_0000_0000_0000;
        base = grantLog.size(); startCnt = reqReadyCnt; respStart = respCnt;
        @(posedge clk); #2;
        for (int i = 0; i < NCH; i++) raise(i, 1'b0, AW'(17'h00100 + i*8), '0);
        for (int j = 0; j < 8; j++) begin
            a = AW'(17'h00100 + (j % NCH)*8);
            push_exp(j % NCH, 1'b0, rBase ^ 64'(a));
        end
        budget = 300;
        while (reqReadyCnt - startCnt < 8 && budget > 0) begin @(negedge clk); #1; budget--; end
        @(posedge clk); #2;
        req_valid = '0;
        wait_drain("round_robin");
        for (int j = 0; j < 8; j++) begin
            got = (base + j < grantLog.size()) ? grantLog[base + j] : -1;
            total++;
            if (got !== (j % NCH)) begin
                bad++;
                $display("FAIL rr_order[%0d]: granted ch%0d, required ch%0d", j, got, j % NCH);
            end
        end
        total++;
        if (reqReadyCnt - startCnt != 8 || respCnt - respStart != 8) begin
            bad++;
            $display("FAIL rr_counts: grants=%0d resps=%0d, required 8/8",
                     reqReadyCnt - startCnt, respCnt - respStart);
        end
    endtask

    task automatic test_single_read();
        rXor = 1'b0; rBase = 64'hDEAD_BEEF_0000_0001;
        push_exp(0, 1'b0, 64'hDEAD_BEEF_0000_0001);
        issue(0, 1'b0, 17'h10008, '0);
        wait_drain("single_read");
        total++;
        if (respCycCh[0] - grantCyc[0] != 3) begin
            bad++;
            $display("FAIL read_latency: %0d cycles, required 3", respCycCh[0] - grantCyc[0]);
        end
        total++;
        if (capAr !== 17'h10008) begin
            bad++;
            $display("FAIL read_addr: ar_addr=%h, required 10008", capAr);
        end
    endtask

    task automatic test_write_stall();
        logic [DW-1:0] d;
        for (int k = 0; k < 3; k++) begin
            awDly = $urandom_range(5, 1);
            wDly  = $urandom_range(5, 1);
            bDly  = $urandom_range(5, 0);
            d = 64'h1234 + 64'(k);
            push_exp(1, 1'b0, '0);
            issue(1, 1'b1, 17'h10010, d);
            wait_drain("write");
            total++;
            if (capAw !== 17'h10010 || capW !== d) begin
                bad++;
                $display("FAIL write_payload: aw_addr=%h w_data=%h, required 10010/%h", capAw, capW, d);
            end
        end
        awDly = 0; wDly = 0; bDly = 0;
    endtask

    task automatic test_slave_error();
        rXor = 1'b0; rBase = 64'h0BAD_0BAD_0BAD_0BAD; rRespCode = 2'b10;
        push_exp(2, 1'b1, '0);
        push_exp(3, 1'b0, '0);
        issue(2, 1'b0, 17'h00040, '0);
        issue(3, 1'b1, 17'h00080, 64'h55);
        wait_drain("slave_error");
        total++;
        if (grantCyc[3] - respCycCh[2] != 1) begin
            bad++;
            $display("FAIL idle_after_resp: next grant %0d cycles after RESP, required 1",
                     grantCyc[3] - respCycCh[2]);
        end
        rRespCode = 2'b00;
    endtask

    task automatic test_timeout();
        rNever = 1'b1;
        push_exp(1, 1'b1, '0);
        issue(1, 1'b0, 17'h00200, '0);
        wait_drain("timeout");
        total++;
        if (respCycCh[1] - rRdyRiseCyc != TMO) begin
            bad++;
            $display("FAIL timeout_cycles: %0d cycles after R entry, required %0d",
                     respCycCh[1] - rRdyRiseCyc, TMO);
        end
        total++;
        if (r_ready !== 1'b0) begin
            bad++;
            $display("FAIL r_ready_after_abort: r_ready=%b, required 0", r_ready);
        end
        rNever = 1'b0;
    endtask

    task automatic test_reset_mid();
        int budget = 50;
        int n;
        wDly = 10;
        issue(1, 1'b1, 17'h00300, 64'hFEED);
        while (w_valid !== 1'b1 && budget > 0) begin @(negedge clk); #1; budget--; end
        total++;
        if (w_valid !== 1'b1) begin
            bad++;
            $display("FAIL reach_w: w_valid=%b, required 1", w_valid);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        wDly = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        rXor = 1'b1; rBase = 64'h7777_0000_0000_0000;
        push_exp(0, 1'b0, rBase ^ 64'(17'h00400));
        push_exp(2, 1'b0, rBase ^ 64'(17'h00500));
        @(posedge clk); #2;
        raise(0, 1'b0, 17'h00400, '0);
        raise(2, 1'b0, 17'h00500, '0);
        await_grant(0);
        await_grant(2);
        wait_drain("after_reset");
        n = grantLog.size();
        total++;
        if (n < 2 || grantLog[n-2] !== 0) begin
            bad++;
            $display("FAIL ptr_after_reset: first grant ch%0d, required ch0", (n < 2) ? -1 : grantLog[n-2]);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_read();
        test_write_stall();
        test_slave_error();
        test_timeout();
        test_reset_mid();
        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
